// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time (i_clk cycles) over N periods; 2-bit register read side.
// Latency: pin edges act SYNC_STAGES+1 cycles later, read data 1 cycle after i_re; no backpressure, all accesses accepted.
module pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pwm,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [1:0]       i_addr,
    input  logic [CNT_W-1:0] i_wdata,
    output logic [CNT_W-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_busy,
    output logic             o_capture_end
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     pwm_q;
    logic                     pwm_s;
    logic                     rise;
    logic                     fall;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         target;
    logic [CNT_W-1:0]         period_q;
    logic [CNT_W-1:0]         high_q;
    logic                     done_q;
    logic                     ovf_q;
    logic                     seen_fall;
    logic                     tgt_wr;
    logic [CNT_W-1:0]         rd_mux;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
            pwm_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_q;
    assign fall  = ~pwm_s & pwm_q;

    // A write arriving together with i_start belongs to the capture being armed.
    assign tgt_wr = i_we && (i_addr == 2'd2) && (!o_busy || i_start);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            target <= CNT_ONE;
        end else if (tgt_wr) begin
            target <= (i_wdata == '0) ? CNT_ONE : i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            count         <= '0;
            period_q      <= '0;
            high_q        <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            seen_fall     <= 1'b0;
            o_busy        <= 1'b0;
            o_capture_end <= 1'b0;
        end else begin
            o_capture_end <= 1'b0;
            if (i_start) begin
                state  <= S_WAIT_RISE;
                o_busy <= 1'b1;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
                count  <= '0;
                cnt    <= '0;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_WAIT_RISE: begin
                        if (rise) begin
                            state     <= S_MEASURE;
                            cnt       <= '0;
                            seen_fall <= 1'b0;
                        end
                    end
                    S_MEASURE: begin
                        // Saturation wins over a coincident rise: that period is unrepresentable.
                        if (cnt == CNT_MAX) begin
                            period_q      <= CNT_MAX;
                            if (!seen_fall) high_q <= CNT_MAX;
                            ovf_q         <= 1'b1;
                            done_q        <= 1'b1;
                            o_capture_end <= 1'b1;
                            o_busy        <= 1'b0;
                            state         <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                            if (fall) begin
                                high_q    <= cnt + CNT_ONE;
                                seen_fall <= 1'b1;
                            end
                            if (rise) begin
                                period_q  <= cnt + CNT_ONE;
                                count     <= count + CNT_ONE;
                                cnt       <= '0;
                                seen_fall <= 1'b0;
                                if (count + CNT_ONE == target) begin
                                    state         <= S_DONE;
                                    done_q        <= 1'b1;
                                    o_capture_end <= 1'b1;
                                    o_busy        <= 1'b0;
                                end
                            end
                        end
                    end
                    S_DONE: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            2'd0:    rd_mux = period_q;
            2'd1:    rd_mux = high_q;
            2'd2:    rd_mux = target;
            default: rd_mux = {{(CNT_W-3){1'b0}}, ovf_q, o_busy, done_q};
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= i_re;
            if (i_re) o_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed vector table, hand-written corner sequences, randomized captures.
module tb_pwm_capture;

    localparam int CNT_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic             i_pwm;
    logic             i_we;
    logic             i_re;
    logic [1:0]       i_addr;
    logic [CNT_W-1:0] i_wdata;
    logic [CNT_W-1:0] o_rdata;
    logic             o_rvalid;
    logic             o_busy;
    logic             o_capture_end;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_pwm         (i_pwm),
        .i_we          (i_we),
        .i_re          (i_re),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_rvalid      (o_rvalid),
        .o_busy        (o_busy),
        .o_capture_end (o_capture_end)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int end_cnt = 0;
    int busy_bad = 0;
    int hq[$];
    int lq[$];

    always @(negedge i_clk) if (o_capture_end) end_cnt++;

    typedef struct {
        logic [15:0] wr_tgt;
        logic [15:0] exp_tgt;
        int          hi;
        int          lo;
        int          nper;
        logic [15:0] exp_per;
        logic [15:0] exp_hi;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic tick_b();
        tick();
        if (!o_busy) busy_bad++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        i_we = 1'b1; i_addr = a; i_wdata = d;
        tick();
        i_we = 1'b0;
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [15:0] exp, input string name);
        i_re = 1'b1; i_addr = a;
        tick();
        i_re = 1'b0;
        chk({name, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
        chk(name, {16'd0, o_rdata}, {16'd0, exp});
    endtask

    task automatic start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic idle_low();
        i_pwm = 1'b0;
        repeat (5) tick();
    endtask

    // Drives hq/lq periods then the closing rise; status sampled early in the last low phase.
    task automatic run_periods(input int n);
        busy_bad = 0;
        for (int i = 0; i < n; i++) begin
            i_pwm = 1'b1;
            repeat (hq[i]) tick_b();
            i_pwm = 1'b0;
            if (i == n - 1) begin
                rd_chk(2'd3, 16'h2, "status_before_last_rise");
                repeat (lq[i] - 1) tick_b();
            end else begin
                repeat (lq[i]) tick_b();
            end
        end
        i_pwm = 1'b1;
        chk("busy_throughout", busy_bad, 0);
    endtask

    task automatic wait_end(input string name, input int budget, output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            tick();
            waited++;
            if (o_capture_end) found = 1'b1;
        end
        chk(name, {31'd0, found}, 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, e0, waited;
        logic [15:0] wt;

        vt[0] = '{wr_tgt: 16'd1, exp_tgt: 16'd1, hi: 30, lo: 70, nper: 1, exp_per: 16'd100, exp_hi: 16'd30};
        vt[1] = '{wr_tgt: 16'd0, exp_tgt: 16'd1, hi: 1,  lo: 9,  nper: 1, exp_per: 16'd10,  exp_hi: 16'd1};
        vt[2] = '{wr_tgt: 16'd2, exp_tgt: 16'd2, hi: 20, lo: 20, nper: 2, exp_per: 16'd40,  exp_hi: 16'd20};
        vt[3] = '{wr_tgt: 16'd3, exp_tgt: 16'd3, hi: 5,  lo: 7,  nper: 3, exp_per: 16'd12,  exp_hi: 16'd5};

        i_rst = 1'b1; i_start = 1'b0; i_pwm = 1'b0; i_we = 1'b0; i_re = 1'b0;
        i_addr = 2'd0; i_wdata = '0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();

        // Reset values.
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_capture_end", {31'd0, o_capture_end}, 32'd0);
        chk("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
        rd_chk(2'd0, 16'd0, "rst_period");
        rd_chk(2'd1, 16'd0, "rst_high");
        rd_chk(2'd2, 16'd1, "rst_target");
        rd_chk(2'd3, 16'd0, "rst_status");

        // Directed vector table: uniform periods.
        foreach (vt[v]) begin
            wr(2'd2, vt[v].wr_tgt);
            rd_chk(2'd2, vt[v].exp_tgt, "tbl_target");
            hq.delete(); lq.delete();
            for (int i = 0; i < vt[v].nper; i++) begin hq.push_back(vt[v].hi); lq.push_back(vt[v].lo); end
            idle_low();
            e0 = end_cnt;
            start();
            run_periods(vt[v].nper);
            wait_end("tbl_capture_end", 40, waited);
            chk("tbl_end_pulses", end_cnt - e0, 1);
            rd_chk(2'd3, 16'h1, "tbl_status");
            rd_chk(2'd0, vt[v].exp_per, "tbl_period");
            rd_chk(2'd1, vt[v].exp_hi, "tbl_high");
            repeat (2) tick();
            chk("tbl_rvalid_drop", {31'd0, o_rvalid}, 32'd0);
            chk("tbl_rdata_hold", {16'd0, o_rdata}, {16'd0, vt[v].exp_hi});
        end

        // Multi-period with a rejected TARGET write while busy.
        wr(2'd2, 16'd4);
        idle_low();
        e0 = end_cnt;
        start();
        wr(2'd2, 16'd9);
        rd_chk(2'd2, 16'd4, "busy_target_write");
        hq = '{10, 10, 10, 10};
        lq = '{40, 50, 60, 70};
        run_periods(4);
        wait_end("multi_capture_end", 40, waited);
        chk("multi_end_pulses", end_cnt - e0, 1);
        rd_chk(2'd0, 16'd80, "multi_period");
        rd_chk(2'd1, 16'd10, "multi_high");
        rd_chk(2'd3, 16'h1, "multi_status");

        // Abort mid-MEASURE with a simultaneous TARGET write, then a 40/20 waveform.
        wr(2'd2, 16'd3);
        idle_low();
        e0 = end_cnt;
        start();
        i_pwm = 1'b1; repeat (50) tick();
        i_pwm = 1'b0; repeat (50) tick();
        i_pwm = 1'b1; repeat (30) tick();
        i_start = 1'b1; i_we = 1'b1; i_addr = 2'd2; i_wdata = 16'd2;
        tick();
        i_start = 1'b0; i_we = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd1);
        rd_chk(2'd0, 16'd100, "abort_period_kept");
        rd_chk(2'd2, 16'd2, "abort_target_with_start");
        i_pwm = 1'b0; repeat (6) tick();
        hq = '{20, 20};
        lq = '{20, 20};
        run_periods(2);
        wait_end("abort_capture_end", 40, waited);
        chk("abort_end_pulses", end_cnt - e0, 1);
        rd_chk(2'd0, 16'd40, "abort_period");
        rd_chk(2'd1, 16'd20, "abort_high");

        // Randomized captures against the period/high model.
        for (int r = 0; r < 6; r++) begin
            w  = $urandom_range(0, 4);
            wt = 16'(w);
            n  = (w == 0) ? 1 : w;
            wr(2'd2, wt);
            rd_chk(2'd2, 16'(n), "rnd_target");
            hq.delete(); lq.delete();
            for (int i = 0; i < n; i++) begin
                hq.push_back($urandom_range(1, 25));
                lq.push_back($urandom_range(1, 25));
            end
            idle_low();
            e0 = end_cnt;
            start();
            run_periods(n);
            wait_end("rnd_capture_end", 40, waited);
            chk("rnd_end_pulses", end_cnt - e0, 1);
            rd_chk(2'd0, 16'(hq[n-1] + lq[n-1]), "rnd_period");
            rd_chk(2'd1, 16'(hq[n-1]), "rnd_high");
            rd_chk(2'd3, 16'h1, "rnd_status");
        end

        // Reset asserted mid-capture.
        wr(2'd2, 16'd2);
        idle_low();
        e0 = end_cnt;
        start();
        i_pwm = 1'b1; repeat (10) tick();
        i_pwm = 1'b0; repeat (10) tick();
        i_pwm = 1'b1; repeat (5) tick();
        rd_chk(2'd2, 16'd2, "midrst_target_before");
        i_rst = 1'b1;
        #1;
        chk("midrst_rdata", {16'd0, o_rdata}, 32'd0);
        chk("midrst_rvalid", {31'd0, o_rvalid}, 32'd0);
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_capture_end", {31'd0, o_capture_end}, 32'd0);
        i_pwm = 1'b0;
        repeat (5) tick();
        i_rst = 1'b0;
        repeat (5) tick();
        chk("midrst_no_end_pulse", end_cnt - e0, 0);
        rd_chk(2'd2, 16'd1, "midrst_target");
        rd_chk(2'd0, 16'd0, "midrst_period");
        rd_chk(2'd3, 16'd0, "midrst_status");

        // Overflow: one rise then held high.
        wr(2'd2, 16'd1);
        idle_low();
        e0 = end_cnt;
        start();
        i_pwm = 1'b1;
        wait_end("ovf_capture_end", 70000, waited);
        chk("ovf_latency_range", {31'd0, (waited >= 65535 && waited <= 65545)}, 32'd1);
        chk("ovf_end_pulses", end_cnt - e0, 1);
        rd_chk(2'd3, 16'h5, "ovf_status");
        rd_chk(2'd0, 16'hFFFF, "ovf_period");
        rd_chk(2'd1, 16'hFFFF, "ovf_high");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measurement-side counterpart of the team's PWM timer. It samples an incoming PWM waveform and measures period and high time in i_clk cycles.
- It counts a programmed number of complete periods, then flags completion.
- Results are exposed through a 2-bit addressed register interface with a read strobe. This is the read side, mirroring the timer's write-programmed configuration registers.

Parameters:
- CNT_W, 16, width of period/high counters, result registers and data bus
- SYNC_STAGES, 2, flip-flop stages on i_pwm before edge detection (minimum 2)

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_start  input  1  one-cycle pulse: arm/re-arm a capture
- i_pwm  input  1  PWM waveform under measurement, asynchronous to i_clk
- i_we  input  1  register write strobe
- i_re  input  1  register read strobe
- i_addr  input  2  register address
- i_wdata  input  CNT_W  write data
- o_rdata  output  CNT_W  registered read data
- o_rvalid  output  1  one-cycle pulse, o_rdata valid
- o_busy  output  1  high in WAIT_RISE or MEASURE
- o_capture_end  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset: all outputs 0; state IDLE; period, high, count and flags 0; target N = 1; synchronizer flops 0.
- Register map:
  - 0 PERIOD (RO): last full period.
  - 1 HIGH (RO): last high time.
  - 2 TARGET (RW): N, the number of periods to capture.
  - 3 STATUS (RO): {zeros, overflow[2], busy[1], done[0]}.
- Writes to RO addresses are ignored.
- A TARGET write while o_busy=1 is ignored.
- Writing 0 to TARGET stores 1.
- Read: i_re at cycle t gives o_rdata and o_rvalid=1 at t+1. o_rdata holds its value until the next read. Reads have no side effects.
- Input path: i_pwm passes through SYNC_STAGES flops. A rise or fall is then detected against one further flop. An edge at the i_pwm pin is seen internally SYNC_STAGES+1 cycles later. All timings below are in internal detected-edge cycles.
- FSM states and transitions:
  - IDLE: wait for i_start.
  - WAIT_RISE: fall edges are ignored; the first rise resets the free counter to 0 and goes to MEASURE.
  - MEASURE: the counter increments each cycle.
    - On a fall: HIGH <= counter+1.
    - On a rise: PERIOD <= counter+1, count <= count+1, counter <= 0.
    - If count+1 == N: go to DONE.
  - DONE: done=1; o_capture_end pulses for exactly one cycle on entry; stay in DONE until i_start.
- Result definition: a rise at cycle t0, fall at t1 and rise at t2 give HIGH = t1-t0 and PERIOD = t2-t0. PERIOD and HIGH update after every period, so they show the last completed period.
- i_start handling:
  - In any state, i_start clears done, overflow, count and counter, then enters WAIT_RISE.
  - This includes a mid-capture abort (restart); PERIOD and HIGH keep their old values until overwritten.
- Simultaneous i_start and i_we to TARGET in the same cycle: the write is accepted and the new N applies to this capture.
- An edge in the same cycle as i_start is ignored.
- Overflow: if the counter reaches 2^CNT_W-1 in MEASURE without a rise:
  - PERIOD <= all ones, overflow=1, go to DONE and pulse o_capture_end.
  - If no fall has occurred since the last rise, HIGH <= all ones.
- WAIT_RISE has no timeout; it waits indefinitely and remains abortable by i_start or reset.
- A single-cycle-wide pulse is valid: a rise and the following fall on consecutive internal cycles give HIGH = 1.
- Reset asserted mid-operation forces the reset values immediately, with no completion pulse.

Test Plan:
- Reset values: reset, then read addrs 0..3 -> rdata 0, 0, 1, 0, each with o_rvalid one cycle after i_re; o_busy=0.
- Basic capture: write TARGET=1, i_start, drive i_pwm high 30 clk / low 70 clk.
  - Response: o_capture_end pulses once at the second detected rise.
  - PERIOD=100, HIGH=30, STATUS=0x1.
- Multi-period: TARGET=4 with periods 50/60/70/80 (high 10 each).
  - Response: done only after the 4th period; PERIOD=80, HIGH=10.
  - o_busy is high throughout, and the write of TARGET=9 made during capture reads back as 4.
- Overflow: TARGET=1, i_start, one rise then i_pwm held high. After 65535 cycles -> STATUS=0x5, PERIOD=0xFFFF, HIGH=0xFFFF, one o_capture_end pulse.
- Abort/restart: i_start mid-MEASURE of a 100-cycle PWM -> count cleared and o_busy stays high. Then feed a 40/20 waveform -> PERIOD=40, HIGH=20.
- Edge cases:
  - TARGET write of 0 -> reads back 1.
  - A 1-cycle high pulse, period 10 -> HIGH=1, PERIOD=10.
  - Asserting i_rst mid-capture -> all outputs 0 at once and no o_capture_end.
